accumulator_control_unit: RTL and testbench
===========================================

# accumulator_control_unit

Fetch/decode/execute sequencer for the 16-bit accumulator datapath. It sits directly upstream of the combinational ALU and drives its opcode and operands, and it owns the PC, IR and accumulator. It also drives the synchronous single-port main memory, which has 16Ki x 16 words, a one-cycle read latency, and no read while writing.

## Interface
Parameters: none. Widths are fixed.

- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-low reset
- run  input  1  when 0, the FSM stalls in FETCH
- mem_addr  output  16  memory address; bits [15:14] always 0
- mem_wdata  output  16  write data (= acc)
- mem_we  output  1  memory write enable
- mem_rdata  input  16  memory data_out, valid the cycle after the address is presented
- alu_opcode  output  4  ALU operation select
- alu_a  output  16  ALU operand1 (= acc)
- alu_b  output  16  ALU operand2 (= mem_rdata)
- alu_result  input  16  ALU result, combinational
- pc  output  16  program counter, zero-extended from 14 bits
- acc  output  16  accumulator
- ir  output  16  instruction register
- halted  output  1  high while in HALTED
- div_zero  output  1  sticky divide-by-zero flag

## Operation

Instruction format, by ir[15:14]:
- 00 system, sub-op ir[13:12]:
  - 00 NOP
  - 01 HALT
  - 10 CLR: acc <= 0
  - 11 JMP: pc <= {4'b0, ir[11:0]}
- 01 LOAD: acc <= mem[ir[13:0]]
- 10 STORE: mem[ir[13:0]] <= acc
- 11 ALU: acc <= ALU(acc, mem[{6'b0, ir[9:0]}]); alu_opcode = ir[13:10]

FSM states: FETCH, IR_LOAD, OPERAND, EXECUTE, HALTED.
- FETCH: mem_addr = pc, mem_we = 0. Advances to IR_LOAD only if run = 1; otherwise holds.
- IR_LOAD: ir <= mem_rdata; pc <= pc + 1, wrapping 0x3FFF -> 0x0000. Next state OPERAND.
- OPERAND: decodes ir.
  - LOAD/ALU: mem_addr = operand address, mem_we = 0; next EXECUTE.
  - STORE: mem_addr = ir[13:0], mem_wdata = acc, mem_we = 1; next FETCH.
  - NOP/CLR/JMP: perform the action; next FETCH.
  - HALT: next HALTED.
- EXECUTE:
  - LOAD: acc <= mem_rdata.
  - ALU: acc <= alu_result, except divide (alu_opcode 0011) with mem_rdata = 0: acc <= 16'hFFFF and div_zero <= 1.
  - Next state FETCH.
- HALTED: terminal. halted = 1, mem_we = 0, no register changes. Only reset exits.

Datapath and output rules:
- alu_a = acc and alu_b = mem_rdata at all times.
- alu_opcode = ir[13:10] at all times.
- Comparison ALU ops load 0 or 1 into acc.
- All arithmetic is modulo 2^16.
- mem_we is high only in OPERAND for a STORE, and is forced 0 whenever reset = 0.

## Timing
- Reset: on any rising edge with reset = 0:
  - state <= FETCH
  - pc, acc, ir <= 0
  - halted, div_zero <= 0
- Reset takes priority over every state, including mid-STORE and HALTED.
- While reset = 0, mem_we = 0 combinationally, so no write reaches memory.
- Instruction latency, counted from entering FETCH with run = 1:
  - LOAD and ALU: 4 cycles.
  - STORE, NOP, CLR and JMP: 3 cycles.
  - HALT: halted rises after 3 cycles.
- run is sampled only in FETCH. Dropping run mid-instruction does not stall; the instruction completes.
- JMP overrides the IR_LOAD increment. The next fetch is from the jump target.
- div_zero clears only on reset.

## Test plan
- Add program. Memory:
  - mem[0] = 0x4100, mem[1] = 0xC101, mem[2] = 0x8102, mem[3] = 0x1000
  - mem[0x100] = 5, mem[0x101] = 7
  - Required: mem[0x102] = 12, acc = 12; halted rises 14 cycles after reset release (run = 1); pc = 4.
- Divide by zero. mem[0] = 0x4100 (mem[0x100] = 9), mem[1] = 0xCD01 (mem[0x101] = 0), mem[2] = 0x1000. Required: acc = 0xFFFF, div_zero = 1, halted = 1.
- Jump. mem[0] = 0x3005, mem[5] = 0x2000, mem[6] = 0x1000, acc preloaded nonzero via LOAD. Required: the fetch after JMP uses mem_addr = 5; acc = 0 after CLR; final pc = 7.
- PC wrap. All memory = 0x0000 (NOP). Required: after 16384 × 3 cycles with run = 1, pc = 0x0000 and mem_we never asserted.
- Reset mid-STORE. Drive reset = 0 during OPERAND of a STORE to 0x200. Required: mem_we = 0 that cycle, mem[0x200] unchanged, and next cycle pc = 0, acc = 0, state FETCH.
- Run stall. Hold run = 0 for 10 cycles after reset. Required: mem_addr = 0, pc = 0, mem_we = 0 throughout; first IR_LOAD occurs the cycle after run rises.

Source files
------------

// File: rtl/accumulator_control_unit.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator datapath.
// Owns PC, IR and accumulator; drives the single-port main memory and the external ALU.
module accumulator_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic [15:0] pc,
    output logic [15:0] acc,
    output logic [15:0] ir,
    output logic        halted,
    output logic        div_zero
);

    // state     | meaning
    // S_FETCH   | present pc to memory; wait here while run = 0
    // S_IR_LOAD | capture instruction word, advance pc
    // S_OPERAND | decode; issue operand read, store, or system action
    // S_EXECUTE | operand data valid; update accumulator
    // S_HALTED  | terminal until reset
    typedef enum logic [2:0] {
        S_FETCH,
        S_IR_LOAD,
        S_OPERAND,
        S_EXECUTE,
        S_HALTED
    } state_t;

    localparam logic [1:0] OP_SYS   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    localparam logic [1:0] SYS_NOP  = 2'b00;
    localparam logic [1:0] SYS_HALT = 2'b01;
    localparam logic [1:0] SYS_CLR  = 2'b10;
    localparam logic [1:0] SYS_JMP  = 2'b11;

    localparam logic [3:0] ALU_DIV  = 4'b0011;

    state_t      state, state_nxt;
    logic [13:0] pc_q;
    logic [15:0] acc_q;
    logic [15:0] ir_q;
    logic        div_zero_q;

    logic [1:0]  op;
    logic [1:0]  sub_op;
    logic [15:0] operand_addr;

    assign op           = ir_q[15:14];
    assign sub_op       = ir_q[13:12];
    assign operand_addr = (op == OP_ALU) ? {6'b0, ir_q[9:0]} : {2'b0, ir_q[13:0]};

    assign pc         = {2'b0, pc_q};
    assign acc        = acc_q;
    assign ir         = ir_q;
    assign div_zero   = div_zero_q;
    assign halted     = (state == S_HALTED);
    assign mem_wdata  = acc_q;
    assign alu_a      = acc_q;
    assign alu_b      = mem_rdata;
    assign alu_opcode = ir_q[13:10];

    always_comb begin
        state_nxt = state;
        mem_addr  = {2'b0, pc_q};
        mem_we    = 1'b0;
        case (state)
            S_FETCH: begin
                if (run) state_nxt = S_IR_LOAD;
            end
            S_IR_LOAD: begin
                state_nxt = S_OPERAND;
            end
            S_OPERAND: begin
                case (op)
                    OP_LOAD, OP_ALU: begin
                        mem_addr  = operand_addr;
                        state_nxt = S_EXECUTE;
                    end
                    OP_STORE: begin
                        mem_addr  = operand_addr;
                        // Gated by reset so an asserted reset can never commit a write.
                        mem_we    = reset;
                        state_nxt = S_FETCH;
                    end
                    default: begin
                        state_nxt = (sub_op == SYS_HALT) ? S_HALTED : S_FETCH;
                    end
                endcase
            end
            S_EXECUTE: begin
                mem_addr  = operand_addr;
                state_nxt = S_FETCH;
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            pc_q       <= '0;
            acc_q      <= '0;
            ir_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IR_LOAD: begin
                    ir_q <= mem_rdata;
                    pc_q <= pc_q + 14'd1;
                end
                S_OPERAND: begin
                    if (op == OP_SYS) begin
                        if (sub_op == SYS_CLR) acc_q <= '0;
                        if (sub_op == SYS_JMP) pc_q <= {2'b0, ir_q[11:0]};
                    end
                end
                S_EXECUTE: begin
                    if (op == OP_LOAD) begin
                        acc_q <= mem_rdata;
                    end else if (alu_opcode == ALU_DIV && mem_rdata == 16'h0000) begin
                        acc_q      <= 16'hFFFF;
                        div_zero_q <= 1'b1;
                    end else begin
                        acc_q <= alu_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_control_unit.sv
// Directed bench for accumulator_control_unit with a behavioural memory and ALU.
module tb_accumulator_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_result;
    logic [15:0] pc, acc, ir;
    logic        halted, div_zero;

    int checks = 0;
    int failures = 0;
    logic we_seen;

    logic [15:0] mem [0:16383];

    accumulator_control_unit dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .pc(pc), .acc(acc), .ir(ir), .halted(halted), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory: one-cycle read latency, no read during a write.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[13:0]] = mem_wdata;
        else        mem_rdata <= mem[mem_addr[13:0]];
    end

    always_comb begin
        case (alu_opcode)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            4'h3:    alu_result = (alu_b == 16'h0) ? 16'h0 : alu_a / alu_b;
            4'h4:    alu_result = alu_a & alu_b;
            4'h8:    alu_result = (alu_a < alu_b) ? 16'h1 : 16'h0;
            default: alu_result = 16'h0;
        endcase
    end

    always @(negedge clk) if (mem_we === 1'b1) we_seen = 1'b1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset(input logic run_val);
        reset = 1'b0;
        run   = run_val;
        step(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = 16'h4100;
        mem[16'h100] = 16'hAAAA;
        reset = 1'b1; run = 1'b1;
        step(5);
        do_reset(1'b0);
        checks++; if (pc !== 16'h0) begin failures++; $display("FAIL reset_pc actual=%h expected=0000", pc); end
        checks++; if (acc !== 16'h0) begin failures++; $display("FAIL reset_acc actual=%h expected=0000", acc); end
        checks++; if (ir !== 16'h0) begin failures++; $display("FAIL reset_ir actual=%h expected=0000", ir); end
        checks++; if (halted !== 1'b0 || div_zero !== 1'b0) begin failures++; $display("FAIL reset_flags halted=%b div_zero=%b expected=0,0", halted, div_zero); end
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we actual=%b expected=0", mem_we); end
    endtask

    task automatic test_add();
        int cnt;
        clear_mem();
        mem[0] = 16'h4100; mem[1] = 16'hC101; mem[2] = 16'h8102; mem[3] = 16'h1000;
        mem[16'h100] = 16'd5; mem[16'h101] = 16'd7;
        do_reset(1'b1);
        cnt = 0;
        while (halted !== 1'b1 && cnt < 100) begin
            step(1);
            cnt++;
        end
        checks++; if (cnt !== 14) begin failures++; $display("FAIL add_halt_latency actual=%0d expected=14", cnt); end
        checks++; if (mem[16'h102] !== 16'd12) begin failures++; $display("FAIL add_store actual=%h expected=000c", mem[16'h102]); end
        checks++; if (acc !== 16'd12) begin failures++; $display("FAIL add_acc actual=%h expected=000c", acc); end
        checks++; if (pc !== 16'd4) begin failures++; $display("FAIL add_pc actual=%h expected=0004", pc); end
        step(3);
        checks++; if (pc !== 16'd4 || halted !== 1'b1) begin failures++; $display("FAIL add_halt_hold pc=%h halted=%b expected=0004,1", pc, halted); end
    endtask

    task automatic test_sub_wrap();
        clear_mem();
        mem[0] = 16'h4100; mem[1] = 16'hC501; mem[2] = 16'h1000;
        mem[16'h100] = 16'd5; mem[16'h101] = 16'd7;
        do_reset(1'b1);
        step(8);
        checks++; if (acc !== 16'hFFFE) begin failures++; $display("FAIL sub_wrap actual=%h expected=fffe", acc); end
        clear_mem();
        mem[0] = 16'h4100; mem[1] = 16'hE101; mem[2] = 16'h1000;
        mem[16'h100] = 16'd5; mem[16'h101] = 16'd7;
        do_reset(1'b1);
        step(8);
        checks++; if (acc !== 16'h0001) begin failures++; $display("FAIL compare_lt actual=%h expected=0001", acc); end
    endtask

    task automatic test_div_zero();
        clear_mem();
        mem[0] = 16'h4100; mem[1] = 16'hCD01; mem[2] = 16'h1000;
        mem[16'h100] = 16'd9; mem[16'h101] = 16'd0;
        do_reset(1'b1);
        step(11);
        checks++; if (acc !== 16'hFFFF) begin failures++; $display("FAIL div_zero_acc actual=%h expected=ffff", acc); end
        checks++; if (div_zero !== 1'b1) begin failures++; $display("FAIL div_zero_flag actual=%b expected=1", div_zero); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL div_zero_halted actual=%b expected=1", halted); end
        do_reset(1'b0);
        checks++; if (div_zero !== 1'b0 || halted !== 1'b0) begin failures++; $display("FAIL div_zero_clear div_zero=%b halted=%b expected=0,0", div_zero, halted); end
    endtask

    task automatic test_jump();
        clear_mem();
        mem[0] = 16'h4100; mem[1] = 16'h3005; mem[5] = 16'h2000; mem[6] = 16'h1000;
        mem[16'h100] = 16'h1234;
        do_reset(1'b1);
        step(4);
        checks++; if (acc !== 16'h1234) begin failures++; $display("FAIL jump_preload actual=%h expected=1234", acc); end
        step(3);
        checks++; if (mem_addr !== 16'h5 || pc !== 16'h5) begin failures++; $display("FAIL jump_target mem_addr=%h pc=%h expected=0005,0005", mem_addr, pc); end
        step(3);
        checks++; if (acc !== 16'h0) begin failures++; $display("FAIL jump_clr actual=%h expected=0000", acc); end
        step(3);
        checks++; if (pc !== 16'h7 || halted !== 1'b1) begin failures++; $display("FAIL jump_final pc=%h halted=%b expected=0007,1", pc, halted); end
    endtask

    task automatic test_reset_mid_store();
        clear_mem();
        mem[0] = 16'h4100; mem[1] = 16'h8200;
        mem[16'h100] = 16'h0055; mem[16'h200] = 16'hBEEF;
        do_reset(1'b1);
        step(6);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h200) begin failures++; $display("FAIL store_operand we=%b addr=%h expected=1,0200", mem_we, mem_addr); end
        reset = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL store_reset_we actual=%b expected=0", mem_we); end
        step(1);
        checks++; if (mem[16'h200] !== 16'hBEEF) begin failures++; $display("FAIL store_reset_mem actual=%h expected=beef", mem[16'h200]); end
        checks++; if (pc !== 16'h0 || acc !== 16'h0 || mem_addr !== 16'h0) begin failures++; $display("FAIL store_reset_regs pc=%h acc=%h addr=%h expected=0000,0000,0000", pc, acc, mem_addr); end
        reset = 1'b1;
        step(2);
        checks++; if (pc !== 16'h1 || ir !== 16'h4100) begin failures++; $display("FAIL store_reset_refetch pc=%h ir=%h expected=0001,4100", pc, ir); end
    endtask

    task automatic test_run_stall();
        int bad;
        clear_mem();
        mem[0] = 16'h4100;
        do_reset(1'b0);
        we_seen = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (mem_addr !== 16'h0 || pc !== 16'h0 || mem_we !== 1'b0) bad++;
        end
        checks++; if (bad !== 0 || we_seen !== 1'b0) begin failures++; $display("FAIL run_stall bad_cycles=%0d we_seen=%b expected=0,0", bad, we_seen); end
        run = 1'b1;
        step(1);
        checks++; if (pc !== 16'h0 || ir !== 16'h0) begin failures++; $display("FAIL run_rise_first pc=%h ir=%h expected=0000,0000", pc, ir); end
        step(1);
        checks++; if (pc !== 16'h1 || ir !== 16'h4100) begin failures++; $display("FAIL run_rise_irload pc=%h ir=%h expected=0001,4100", pc, ir); end
    endtask

    task automatic test_run_drop();
        clear_mem();
        mem[0] = 16'h4100; mem[16'h100] = 16'h0777;
        do_reset(1'b1);
        step(1);
        run = 1'b0;
        step(3);
        checks++; if (acc !== 16'h0777) begin failures++; $display("FAIL run_drop_complete actual=%h expected=0777", acc); end
        step(4);
        checks++; if (pc !== 16'h1 || mem_addr !== 16'h1) begin failures++; $display("FAIL run_drop_stall pc=%h addr=%h expected=0001,0001", pc, mem_addr); end
    endtask

    task automatic test_pc_wrap();
        clear_mem();
        do_reset(1'b1);
        we_seen = 1'b0;
        step(3);
        checks++; if (pc !== 16'h1) begin failures++; $display("FAIL wrap_first_nop actual=%h expected=0001", pc); end
        step(16384 * 3 - 3);
        checks++; if (pc !== 16'h0) begin failures++; $display("FAIL wrap_pc actual=%h expected=0000", pc); end
        checks++; if (we_seen !== 1'b0) begin failures++; $display("FAIL wrap_we actual=%b expected=0", we_seen); end
    endtask

    initial begin
        reset = 1'b0;
        run = 1'b0;
        we_seen = 1'b0;
        test_reset();
        test_add();
        test_sub_wrap();
        test_div_zero();
        test_jump();
        test_reset_mid_store();
        test_run_stall();
        test_run_drop();
        test_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
